// File: rtl/move_key_ctrl.sv
// Horizontal-move key front end for the frog: synchronises and debounces the
// active-low left/right board keys, then a shared FSM turns clean presses into
// single-cycle L/R move requests with hold-to-repeat, L/R mutual exclusion and
// a freeze while a win/lose result is on screen.
module move_key_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 20,
  parameter int unsigned REPEAT_RATE     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic keyL_n,
  input  logic keyR_n,
  input  logic freeze,
  output logic L,
  output logic R,
  output logic heldL,
  output logic heldR
);

  localparam int unsigned MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_P  = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
  localparam int unsigned CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RR_LAST  = CW'(REPEAT_RATE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT,
    BLOCKED
  } state_t;

  // Index 0 is the left key, index 1 the right key throughout.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    pressed;
  logic [1:0]    held;
  logic [1:0]    held_next;
  logic [1:0]    press;
  logic [CW-1:0] dcnt [2];

  state_t        state;
  logic          act;
  logic [CW-1:0] rcnt;

  assign pressed = ~sync2;
  assign heldL   = held[0];
  assign heldR   = held[1];

  // Two-flop synchroniser per key; idles at 1 (released).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {keyR_n, keyL_n};
      sync2 <= sync1;
    end
  end

  // Value held takes at this edge; lets the FSM react on the same edge held flips.
  always_comb begin
    held_next = held;
    for (int unsigned i = 0; i < 2; i++) begin
      if ((pressed[i] != held[i]) && (dcnt[i] == DB_LAST))
        held_next[i] = ~held[i];
    end
    press = held_next & ~held;
  end

  // Debounce: count consecutive disagreement cycles, flip held when the count completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held <= '0;
      for (int unsigned i = 0; i < 2; i++) dcnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (pressed[i] == held[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DB_LAST) begin
          dcnt[i] <= '0;
          held[i] <= ~held[i];
        end else if (dcnt[i] != '1) begin
          dcnt[i] <= dcnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Move FSM: freeze beats everything, then both-keys blocking, then press/repeat.
  // Decisions use held_next so a press and its first pulse register on the same edge,
  // and a release on the edge of a due repeat suppresses that repeat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      act   <= 1'b0;
      rcnt  <= '0;
      L     <= 1'b0;
      R     <= 1'b0;
    end else begin
      L <= 1'b0;
      R <= 1'b0;
      if (freeze) begin
        state <= IDLE;
        rcnt  <= '0;
      end else if (held_next[0] && held_next[1]) begin
        state <= BLOCKED;
        rcnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (press[0]) begin
              L     <= 1'b1;
              act   <= 1'b0;
              rcnt  <= '0;
              state <= DELAY;
            end else if (press[1]) begin
              R     <= 1'b1;
              act   <= 1'b1;
              rcnt  <= '0;
              state <= DELAY;
            end
          end
          DELAY: begin
            if (!held_next[act]) begin
              rcnt  <= '0;
              state <= IDLE;
            end else if (rcnt == RD_LAST) begin
              {R, L} <= act ? 2'b10 : 2'b01;
              rcnt   <= '0;
              state  <= REPEAT;
            end else if (rcnt != '1) begin
              rcnt <= rcnt + CNT_ONE;
            end
          end
          REPEAT: begin
            if (!held_next[act]) begin
              rcnt  <= '0;
              state <= IDLE;
            end else if (rcnt == RR_LAST) begin
              {R, L} <= act ? 2'b10 : 2'b01;
              rcnt   <= '0;
            end else if (rcnt != '1) begin
              rcnt <= rcnt + CNT_ONE;
            end
          end
          BLOCKED: begin
            if (!held_next[0] && !held_next[1]) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
